ps2_key_decoder: RTL
====================

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 SHALL have parameter N_KEYS, default 16: number of decoded key channels, 1..32.
REQ-002 SHALL have parameter KEY_CODES, default 0, width 9*N_KEYS: per-channel scan code, bit 8 = E0-extended, bits 7:0 = code.
REQ-003 SHALL have parameter KEY_MODES, default 0, width 2*N_KEYS: per-channel mode; 0 LEVEL, 1 PULSE, 2 REPEAT, 3 reserved (behaves as LEVEL).
REQ-004 SHALL have parameter REPEAT_DELAY, default 25_000_000: cycles from press to first auto-repeat pulse, at least 2.
REQ-005 SHALL have parameter REPEAT_RATE, default 5_000_000: cycles between subsequent repeat pulses, at least 2.
REQ-006 SHALL have parameter PREFIX_TIMEOUT, default 1_000_000: cycles a parser prefix state may wait for its next byte.
REQ-007 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-008 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-009 SHALL have port rx_data, input, 8: received PS/2 byte.
REQ-010 SHALL have port rx_valid, input, 1: one-cycle strobe, rx_data valid.
REQ-011 SHALL have port flush, input, 1: synchronous release of all keys.
REQ-012 SHALL have port keys, output, N_KEYS: per-channel event/level per mode.
REQ-013 SHALL have port held, output, N_KEYS: per-channel physical pressed state.

Function
REQ-014 Parser FSM SHALL have states IDLE, EXT, BRK, EXT_BRK, advancing only on rx_valid.
REQ-015 In IDLE: E0 -> EXT; F0 -> BRK; any other byte -> make {0,byte}, stay in IDLE.
REQ-016 In EXT: F0 -> EXT_BRK; E0 -> stay in EXT; any other byte -> make {1,byte}, go to IDLE.
REQ-017 In BRK: any byte -> break {0,byte}, go to IDLE; in EXT_BRK: any byte -> break {1,byte}, go to IDLE.
REQ-018 Any non-IDLE state with no rx_valid for PREFIX_TIMEOUT cycles SHALL return to IDLE with no event.
REQ-019 A make matching KEY_CODES[i] SHALL set held[i] at the next edge; a matching break SHALL clear it; unmatched codes SHALL be ignored; multiple channels with equal codes SHALL update together.
REQ-020 LEVEL channel: keys[i] SHALL equal held[i].
REQ-021 PULSE channel: keys[i] SHALL be high for exactly one cycle, aligned with held[i] rising; typematic re-makes while held SHALL produce no pulse.
REQ-022 REPEAT channel: SHALL give an initial pulse as for PULSE, then pulses at press+REPEAT_DELAY and every REPEAT_RATE cycles after, while held.
REQ-023 A single shared repeat engine SHALL track the most recently pressed REPEAT channel; a new REPEAT press SHALL retarget it and restart the delay; releasing the tracked key SHALL stop it; releasing an untracked key SHALL not affect it.
REQ-024 Latency: final byte strobe at cycle t -> held/keys change visible after edge t+1.
REQ-025 flush SHALL clear all held, stop the repeat engine, and suppress all pulses in that cycle; flush SHALL take priority over a simultaneous make.
REQ-026 A break for a key not held SHALL be a no-op; a make for a held key SHALL not restart repeat timing.
REQ-027 Timer counters SHALL be sized $clog2(max(param)+1) and SHALL saturate/reload, never wrap.

Reset
REQ-028 rst SHALL asynchronously force FSM=IDLE, held=0, keys=0, all counters=0, repeat engine idle.
REQ-029 rst asserted mid-sequence (for example after F0) SHALL discard the pending prefix; the first byte after release SHALL be decoded from IDLE.

Structure
REQ-030 Mode encodings, FSM state encodings, and prefix constants (E0, F0) SHALL live in the shared defines file, alongside the existing KEY_* indices.
REQ-031 The repeat engine SHALL be a sub-module, ps2_repeat_timer: ports clk, rst, start, stop, and a one-cycle tick output.

Verification
REQ-032 KEY_CODES[0]=075, mode PULSE; send 75, 75, 75, F0 75 -> keys[0] one pulse after the first 75; held[0] high until the cycle after the break.
REQ-033 KEY_CODES[1]=175, mode LEVEL; send E0 75 then E0 F0 75 -> held[1]=keys[1]=1 between them; channel 0 unaffected.
REQ-034 REPEAT_DELAY=10, REPEAT_RATE=4; press repeat key at t -> pulses at t+1, t+11, t+15, t+19; release -> no further pulses.
REQ-035 Send E0, then idle PREFIX_TIMEOUT+1 cycles, then 75 -> decoded as non-extended make 075.
REQ-036 Send F0, assert rst, release rst, then send 75 -> make (not break), held[0]=1; flush asserted with a simultaneous make -> held=0, keys=0.

Source files
------------

// File: rtl/ps2_key_decoder_pkg.sv
// rtl/ps2_key_decoder_pkg.sv - shared constants, modes and parser states for the PS/2 key decoder
package ps2_key_decoder_pkg;

  // Channel indices used by the board-level key map.
  localparam int KEY_LEFT  = 0;
  localparam int KEY_RIGHT = 1;
  localparam int KEY_UP    = 2;
  localparam int KEY_DOWN  = 3;
  localparam int KEY_FIRE  = 4;

  // Per-channel output modes; the reserved encoding behaves as LEVEL.
  localparam logic [1:0] MODE_LEVEL  = 2'd0;
  localparam logic [1:0] MODE_PULSE  = 2'd1;
  localparam logic [1:0] MODE_REPEAT = 2'd2;
  localparam logic [1:0] MODE_RSVD   = 2'd3;

  // Scan-code prefix bytes.
  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } parse_state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ps2_repeat_timer.sv
// rtl/ps2_repeat_timer.sv - shared typematic auto-repeat timer
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-high reset
//   start - (re)arm: first tick REPEAT_DELAY cycles after the key's initial pulse
//   stop  - disarm; wins over start
//   tick  - one-cycle request for a repeat pulse (registered downstream)
module ps2_repeat_timer
  import ps2_key_decoder_pkg::*;
#(
  parameter int REPEAT_DELAY = 25_000_000,
  parameter int REPEAT_RATE  = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic stop,
  output logic tick
);

  localparam int CW = $clog2(max2(REPEAT_DELAY, REPEAT_RATE) + 1);

  logic          active_q;
  logic [CW-1:0] cnt_q;

  // The consumer registers tick, so loading N-1 places the pulse N cycles
  // after the previous one as seen on the outputs.
  assign tick = active_q && (cnt_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
    end else if (stop) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
    end else if (start) begin
      active_q <= 1'b1;
      cnt_q    <= CW'(REPEAT_DELAY - 1);
    end else if (tick) begin
      cnt_q    <= CW'(REPEAT_RATE - 1);
    end else if (active_q && cnt_q != '0) begin
      cnt_q    <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 scan-code parser with per-channel level/pulse/repeat key outputs
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-high reset
//   rx_data  - received PS/2 byte
//   rx_valid - one-cycle strobe qualifying rx_data
//   flush    - synchronous release of every key
//   keys     - per-channel output shaped by KEY_MODES
//   held     - per-channel physical pressed state
module ps2_key_decoder
  import ps2_key_decoder_pkg::*;
#(
  parameter int                  N_KEYS         = 16,
  parameter logic [9*N_KEYS-1:0] KEY_CODES      = '0,
  parameter logic [2*N_KEYS-1:0] KEY_MODES      = '0,
  parameter int                  REPEAT_DELAY   = 25_000_000,
  parameter int                  REPEAT_RATE    = 5_000_000,
  parameter int                  PREFIX_TIMEOUT = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              flush,
  output logic [N_KEYS-1:0] keys,
  output logic [N_KEYS-1:0] held
);

  localparam int            PW     = $clog2(PREFIX_TIMEOUT + 1);
  localparam logic [PW-1:0] P_LAST = PW'(PREFIX_TIMEOUT - 1);

  parse_state_t  state_q, state_d;
  logic [PW-1:0] pcnt_q;
  logic          evt_make, evt_brk;
  logic [8:0]    evt_code;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      if (rx_valid || state_q == ST_IDLE)
        pcnt_q <= '0;
      else if (pcnt_q != P_LAST)
        pcnt_q <= pcnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    evt_make = 1'b0;
    evt_brk  = 1'b0;
    evt_code = '0;
    if (rx_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (rx_data == PS2_EXT)      state_d = ST_EXT;
          else if (rx_data == PS2_BRK) state_d = ST_BRK;
          else begin
            evt_make = 1'b1;
            evt_code = {1'b0, rx_data};
          end
        end
        ST_EXT: begin
          if (rx_data == PS2_BRK)      state_d = ST_EXT_BRK;
          else if (rx_data != PS2_EXT) begin
            evt_make = 1'b1;
            evt_code = {1'b1, rx_data};
            state_d  = ST_IDLE;
          end
        end
        ST_BRK: begin
          evt_brk  = 1'b1;
          evt_code = {1'b0, rx_data};
          state_d  = ST_IDLE;
        end
        default: begin
          evt_brk  = 1'b1;
          evt_code = {1'b1, rx_data};
          state_d  = ST_IDLE;
        end
      endcase
    end else if (state_q != ST_IDLE && pcnt_q == P_LAST) begin
      // A prefix that never got its follow-up byte is dropped silently.
      state_d = ST_IDLE;
    end
  end

  logic [N_KEYS-1:0] match, rise, held_q, held_d, keys_q, keys_d;
  logic [4:0]        tracked_q, tracked_d;
  logic              rpt_start, rpt_stop, rpt_tick;

  always_comb begin
    held_d    = held_q;
    keys_d    = '0;
    rise      = '0;
    match     = '0;
    tracked_d = tracked_q;
    rpt_start = 1'b0;
    rpt_stop  = flush;
    for (int i = 0; i < N_KEYS; i++) begin
      match[i] = (KEY_CODES[9*i +: 9] == evt_code);
      if (flush)                   held_d[i] = 1'b0;
      else if (evt_make && match[i]) held_d[i] = 1'b1;
      else if (evt_brk && match[i])  held_d[i] = 1'b0;
      // Only a fresh press counts; typematic re-makes of a held key do not.
      rise[i] = !flush && evt_make && match[i] && !held_q[i];
      // Highest-index repeat channel wins when several share a code.
      if (rise[i] && KEY_MODES[2*i +: 2] == MODE_REPEAT) begin
        rpt_start = 1'b1;
        tracked_d = 5'(i);
      end
      if (evt_brk && match[i] && tracked_q == 5'(i))
        rpt_stop = 1'b1;
    end
    for (int i = 0; i < N_KEYS; i++) begin
      case (KEY_MODES[2*i +: 2])
        MODE_PULSE:  keys_d[i] = rise[i];
        MODE_REPEAT: keys_d[i] = rise[i] ||
                                 (rpt_tick && !rpt_start && !rpt_stop && tracked_q == 5'(i));
        default:     keys_d[i] = held_d[i];
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held_q    <= '0;
      keys_q    <= '0;
      tracked_q <= '0;
    end else begin
      held_q    <= held_d;
      keys_q    <= keys_d;
      tracked_q <= tracked_d;
    end
  end

  ps2_repeat_timer #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE)
  ) u_repeat (
    .clk   (clk),
    .rst   (rst),
    .start (rpt_start),
    .stop  (rpt_stop),
    .tick  (rpt_tick)
  );

  assign keys = keys_q;
  assign held = held_q;

endmodule
